conv_pack_ctrl: RTL

Controller that arbitrates convolution result lanes into a packing register and sequences 64-bit writes into the result FIFO. Each lane delivers 20-bit convolution results over a valid/ready handshake. The block packs three results per word, sets the word-valid MSB, and stalls on FIFO full. A frame-last marker flushes a partial word. It sits between the convolution engines and the result FIFO and owns all FIFO write timing.

---
 rtl/conv_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/conv_pack_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared word layout, slot offsets and FSM encoding
// for the convolution result packing controller.
package conv_pkg;

    localparam int WORD_VALID_BIT = 63;
    localparam int WORD_LAST_BIT  = 62;
    localparam int WORD_CNT_MSB   = 61;
    localparam int WORD_CNT_LSB   = 60;
    localparam int SLOT_W         = 20;

    localparam int SLOT0_LSB = 40;
    localparam int SLOT1_LSB = 20;
    localparam int SLOT2_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    function automatic logic [63:0] pack_word(
        input logic                  last,
        input logic [1:0]            nelem,
        input logic [3*SLOT_W-1:0]   slots
    );
        logic [63:0] w;
        w                                = '0;
        w[WORD_VALID_BIT]                = 1'b1;
        w[WORD_LAST_BIT]                 = last;
        w[WORD_CNT_MSB:WORD_CNT_LSB]     = nelem;
        w[3*SLOT_W-1:0]                  = slots;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward
// from the pointer, plus the pointer after that grant.
module rr_arbiter #(
    parameter int NUM_LANES = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [PTR_W-1:0]     next_ptr
);

    int   idx;
    logic found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx = (int'(ptr) + i) % NUM_LANES;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % NUM_LANES);
            end
        end
    end

endmodule

// File: rtl/conv_pack_ctrl.sv
// Packs lane results three per 64-bit word and owns
// all result FIFO write timing.
module conv_pack_ctrl #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 20,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LANES-1:0]          lane_valid,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_data,
    input  logic [NUM_LANES-1:0]          lane_last,
    output logic [NUM_LANES-1:0]          lane_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [63:0]                   fifo_wdata,
    output logic [CNT_W-1:0]              word_count,
    output logic                          frame_done
);

    import conv_pkg::*;

    localparam int PTR_W =
        (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_t                 state;
    state_t                 next_state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       next_ptr;
    logic [NUM_LANES-1:0]   req;
    logic [NUM_LANES-1:0]   grant;
    logic [1:0]             slot;
    logic [1:0]             nelem;
    logic                   last_flag;
    logic [3*SLOT_W-1:0]    slots;
    logic [DATA_W-1:0]      win_data;
    logic                   win_last;
    logic                   accept;
    logic                   word_done;
    logic                   wr;

    assign req = (state == S_FILL) ? lane_valid : '0;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                win_data = lane_data[i*DATA_W +: DATA_W];
                win_last = lane_last[i];
            end
        end
    end

    assign accept     = |grant;
    assign word_done  = accept && (slot == 2'd2 || win_last);
    assign wr         = (state == S_PUSH) && !fifo_full;
    assign lane_ready = grant;
    assign fifo_wr_en = wr;
    assign fifo_wdata = (state == S_PUSH)
                      ? pack_word(last_flag, nelem, slots)
                      : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  next_state = S_FILL;
            S_FILL:  if (word_done) next_state = S_PUSH;
            S_PUSH:  if (wr) next_state = S_FILL;
            default: next_state = S_IDLE;
        endcase
    end

    // accept and wr never coincide: one needs S_FILL, the other S_PUSH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            slot       <= '0;
            slots      <= '0;
            nelem      <= '0;
            last_flag  <= 1'b0;
            word_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wr && last_flag;
            if (accept) begin
                ptr <= next_ptr;
                unique case (slot)
                    2'd0: slots[SLOT0_LSB +: SLOT_W] <= SLOT_W'(win_data);
                    2'd1: slots[SLOT1_LSB +: SLOT_W] <= SLOT_W'(win_data);
                    2'd2: slots[SLOT2_LSB +: SLOT_W] <= SLOT_W'(win_data);
                    default: ;
                endcase
                if (word_done) begin
                    nelem     <= slot + 2'd1;
                    last_flag <= win_last;
                end else begin
                    slot <= slot + 2'd1;
                end
            end
            if (wr) begin
                slot       <= '0;
                slots      <= '0;
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule
